parity_serial_tx: RTL

- Parity-generating serial transmitter; the sending end for the team's switch-word parity checker.
- On a `send` request, latches `sw[7:0]` and computes the parity bit.
- Shifts out an 11-bit frame on `tx`: start bit, 8 data bits LSB first, parity bit, stop bit.
- Drives `led[1:0]` with the odd/even status of the latched word for on-board inspection. Sits between the switch bank and a serial line / pin header.

---
 rtl/parity_serial_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: sends start, 8 data bits LSB first, parity and stop bits on tx, and shows the latched word's odd/even status on led.
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] led
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] led_q, led_d;
  logic end_bit;
  assign end_bit = baud_q == LAST;
  // tx_d is the value for the state being entered, so tx stays a plain register
  always_comb begin
    state_d = state_q;
    baud_d  = state_q == IDLE ? baud_q : (end_bit ? '0 : baud_q + BW'(1));
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;
    case (state_q)
      IDLE: if (send) begin
        state_d = START;
        shift_d = sw;
        par_d   = ^sw ^ PARITY_ODD;
        led_d   = {~^sw, ^sw};
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        baud_d  = '0;
      end
      START: if (end_bit) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (end_bit) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? PARITY : DATA;
        tx_d    = bit_q == 3'd7 ? par_q : shift_q[1];
      end
      PARITY: if (end_bit) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (end_bit) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        tx_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign led  = led_q;
endmodule
